// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command sequencer: opcodes,
// command word layout, FSM states and the guaranteed no-op drive values.
package calc_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_UNDEF = 3'b011;
  localparam logic [2:0] OP_ANDN  = 3'b100;
  localparam logic [2:0] OP_ORN   = 3'b101;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_SLT   = 3'b111;

  localparam int CMD_W    = 11;
  localparam int CTRL_MSB = 10;
  localparam int CTRL_LSB = 8;
  localparam int RD_MSB   = 7;
  localparam int RD_LSB   = 6;
  localparam int WE_MSB   = 5;
  localparam int WE_LSB   = 4;
  localparam int IMM_MSB  = 3;
  localparam int IMM_LSB  = 0;

  // reg0 = reg0 | 0 leaves the calculator untouched on its free-running write
  localparam logic [1:0] NOOP_RD_ADDR = 2'd0;
  localparam logic [1:0] NOOP_WE_ADDR = 2'd0;
  localparam logic [3:0] NOOP_IMM     = 4'd0;
  localparam logic [2:0] NOOP_CTRL    = OP_OR;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_READ = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0] control;
    logic [1:0] rdAddr;
    logic [1:0] weAddr;
    logic [3:0] immediate;
  } cmd_t;

  function automatic cmd_t unpackCmd(input logic [CMD_W-1:0] word);
    cmd_t c;
    c.control   = word[CTRL_MSB:CTRL_LSB];
    c.rdAddr    = word[RD_MSB:RD_LSB];
    c.weAddr    = word[WE_MSB:WE_LSB];
    c.immediate = word[IMM_MSB:IMM_LSB];
    return c;
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Command and response handshake bundle between a command producer/consumer
// (master) and the calculator sequencer (slave).
interface calc_sequencer_if;
  import calc_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CMD_W-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_data;
  logic [1:0]       rsp_tag;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

endinterface

// File: rtl/calc_sequencer_fifo.sv
// Command buffer: FIFO_DEPTH x 11-bit FIFO with count-based full/empty.
// No push-through when full, and a pushed word is visible one edge later.
module cmd_fifo
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [CMD_W-1:0] pushData_i,
  input  logic             pop_i,
  output logic [CMD_W-1:0] popData_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  assign full_o    = (count_q == CW'(FIFO_DEPTH));
  assign empty_o   = (count_q == '0);
  assign popData_o = mem_q[rdPtr_q];
  assign doPush    = push_i & ~full_o;
  assign doPop     = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_q + CW'(doPush) - CW'(doPop);
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Issues buffered commands to the calculator one at a time (EXEC), reads the
// written register back (READ) and holds a tagged response (RESP).
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  calc_sequencer_if.slave      bus,
  output logic [1:0]           calc_rd_addr,
  output logic [1:0]           calc_we_addr,
  output logic [3:0]           calc_immediate,
  output logic [2:0]           calc_control,
  input  logic [3:0]           calc_rd_data
);

  state_e           state_q, state_d;
  logic [1:0]       calcRd_q, calcRd_d;
  logic [1:0]       calcWe_q, calcWe_d;
  logic [3:0]       calcImm_q, calcImm_d;
  logic [2:0]       calcCtrl_q, calcCtrl_d;
  logic             rspValid_q, rspValid_d;
  logic [3:0]       rspData_q, rspData_d;
  logic [1:0]       rspTag_q, rspTag_d;
  logic             rspErr_q, rspErr_d;
  logic             pendErr_q, pendErr_d;
  logic             fifoFull, fifoEmpty, fifoPop;
  logic [CMD_W-1:0] fifoData;
  cmd_t             headCmd;

  cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) uCmdFifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (bus.cmd_valid),
    .pushData_i (bus.cmd_data),
    .pop_i      (fifoPop),
    .popData_o  (fifoData),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  assign headCmd        = unpackCmd(fifoData);
  assign bus.cmd_ready  = ~fifoFull;
  assign bus.rsp_valid  = rspValid_q;
  assign bus.rsp_data   = rspData_q;
  assign bus.rsp_tag    = rspTag_q;
  assign bus.rsp_err    = rspErr_q;
  assign calc_rd_addr   = calcRd_q;
  assign calc_we_addr   = calcWe_q;
  assign calc_immediate = calcImm_q;
  assign calc_control   = calcCtrl_q;

  // Reset forces the no-op immediately so an in-flight EXEC write is suppressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      calcRd_q   <= NOOP_RD_ADDR;
      calcWe_q   <= NOOP_WE_ADDR;
      calcImm_q  <= NOOP_IMM;
      calcCtrl_q <= NOOP_CTRL;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      rspTag_q   <= '0;
      rspErr_q   <= 1'b0;
      pendErr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      calcRd_q   <= calcRd_d;
      calcWe_q   <= calcWe_d;
      calcImm_q  <= calcImm_d;
      calcCtrl_q <= calcCtrl_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      rspTag_q   <= rspTag_d;
      rspErr_q   <= rspErr_d;
      pendErr_q  <= pendErr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    calcRd_d   = calcRd_q;
    calcWe_d   = calcWe_q;
    calcImm_d  = calcImm_q;
    calcCtrl_d = calcCtrl_q;
    rspValid_d = rspValid_q;
    rspData_d  = rspData_q;
    rspTag_d   = rspTag_q;
    rspErr_d   = rspErr_q;
    pendErr_d  = pendErr_q;
    fifoPop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          state_d = ST_EXEC;
        end
      end
      // Rewrite the target with itself so READ sees the EXEC result
      ST_EXEC: begin
        calcRd_d   = calcWe_q;
        calcImm_d  = NOOP_IMM;
        calcCtrl_d = OP_OR;
        state_d    = ST_READ;
      end
      ST_READ: begin
        rspValid_d = 1'b1;
        rspData_d  = calc_rd_data;
        rspTag_d   = calcWe_q;
        rspErr_d   = pendErr_q;
        calcRd_d   = NOOP_RD_ADDR;
        calcWe_d   = NOOP_WE_ADDR;
        calcImm_d  = NOOP_IMM;
        calcCtrl_d = NOOP_CTRL;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rspValid_d = 1'b0;
          if (!fifoEmpty) begin
            fifoPop = 1'b1;
            state_d = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fifoPop) begin
      calcRd_d   = headCmd.rdAddr;
      calcWe_d   = headCmd.weAddr;
      calcImm_d  = headCmd.immediate;
      calcCtrl_d = headCmd.control;
      pendErr_d  = (headCmd.control == OP_UNDEF);
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench: calc_sequencer driving a behavioural calculator,
// with an in-order response model checked on every negedge.
module tb_calc_sequencer;

  localparam logic [2:0] T_AND = 3'b000, T_OR = 3'b001, T_ADD = 3'b010, T_UNDEF = 3'b011;
  localparam logic [2:0] T_ANDN = 3'b100, T_ORN = 3'b101, T_SUB = 3'b110, T_SLT = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_sequencer_if bus();

  logic [1:0] calcRdAddr, calcWeAddr;
  logic [3:0] calcImm, calcRdData;
  logic [2:0] calcCtrl;

  calc_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .calc_rd_addr   (calcRdAddr),
    .calc_we_addr   (calcWeAddr),
    .calc_immediate (calcImm),
    .calc_control   (calcCtrl),
    .calc_rd_data   (calcRdData)
  );

  function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      T_AND:   return a & b;
      T_OR:    return a | b;
      T_ADD:   return a + b;
      T_UNDEF: return 4'd0;
      T_ANDN:  return a & ~b;
      T_ORN:   return a | ~b;
      T_SUB:   return a - b;
      T_SLT:   return (a < b) ? 4'd1 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  // Calculator: register file written on every falling edge, no write enable
  logic [3:0] calcRegs [4] = '{default: 4'd0};
  always @(negedge clk) calcRegs[calcWeAddr] <= alu(calcRegs[calcRdAddr], calcImm, calcCtrl);
  assign calcRdData = calcRegs[calcRdAddr];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [10:0] cmdQ [$];
  logic [3:0]  modelRegs [4] = '{default: 4'd0};
  int          hsCycles [$];
  int          cycle = 0;
  int          rspCount = 0;
  logic        stall = 1'b0;
  logic [6:0]  held;
  logic [10:0] mWord;
  logic [3:0]  mRes;

  // Model: each accepted command executes in order; response = new target value
  always @(negedge clk) begin
    cycle++;
    if (!rst_n) begin
      cmdQ.delete();
      stall = 1'b0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) cmdQ.push_back(bus.cmd_data);
      if (bus.rsp_valid) begin
        checkOutput("rsp_noop_calc", {calcRdAddr, calcWeAddr, calcImm, calcCtrl}, {2'd0, 2'd0, 4'd0, T_OR});
        if (stall) checkOutput("rsp_stable", {bus.rsp_data, bus.rsp_tag, bus.rsp_err}, held);
        if (bus.rsp_ready) begin
          if (cmdQ.size() == 0) begin
            checkOutput("rsp_unexpected", 1, 0);
          end else begin
            mWord = cmdQ.pop_front();
            mRes  = alu(modelRegs[mWord[7:6]], mWord[3:0], mWord[10:8]);
            modelRegs[mWord[5:4]] = mRes;
            checkOutput("rsp_model", {bus.rsp_data, bus.rsp_tag, bus.rsp_err},
                        {mRes, mWord[5:4], mWord[10:8] == T_UNDEF});
          end
          hsCycles.push_back(cycle);
          rspCount++;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          held  = {bus.rsp_data, bus.rsp_tag, bus.rsp_err};
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] we, input logic [3:0] imm);
    logic done;
    done = 1'b0;
    bus.cmd_data  = {op, rd, we, imm};
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) done = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 1, 0);
  endtask

  // Accept at edge P: rsp_valid low through READ, high after edge P+3
  task automatic runSingle(input string name, input logic [2:0] op, input logic [1:0] rd, input logic [1:0] we,
                           input logic [3:0] imm, input logic [3:0] expData, input logic [1:0] expTag, input logic expErr);
    applyStimulus(op, rd, we, imm);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput({name, "_early"}, bus.rsp_valid, 0);
    end
    @(negedge clk);
    checkOutput({name, "_valid"}, bus.rsp_valid, 1);
    checkOutput({name, "_data"}, bus.rsp_data, expData);
    checkOutput({name, "_tag"}, bus.rsp_tag, expTag);
    checkOutput({name, "_err"}, bus.rsp_err, expErr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   base;
    int   hsStart;
    int   n;
    logic accepted;
    logic sawValid;

    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_rsp_fields", {bus.rsp_data, bus.rsp_tag, bus.rsp_err}, 0);
    checkOutput("rst_calc_noop", {calcRdAddr, calcWeAddr, calcImm, calcCtrl}, {2'd0, 2'd0, 4'd0, T_OR});
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("idle_regs", {calcRegs[3], calcRegs[2], calcRegs[1], calcRegs[0]}, 0);
    checkOutput("idle_calc_noop", {calcRdAddr, calcWeAddr, calcImm, calcCtrl}, {2'd0, 2'd0, 4'd0, T_OR});

    $display("[TB] ADD chain");
    runSingle("add5",  T_ADD, 2'd1, 2'd1, 4'd5, 4'd5,  2'd1, 1'b0);
    runSingle("add9",  T_ADD, 2'd1, 2'd1, 4'd9, 4'd14, 2'd1, 1'b0);
    runSingle("add3w", T_ADD, 2'd1, 2'd1, 4'd3, 4'd1,  2'd1, 1'b0);

    $display("[TB] undefined opcode");
    runSingle("undef", T_UNDEF, 2'd1, 2'd1, 4'd7, 4'd0, 2'd1, 1'b1);
    checkOutput("undef_reg1", calcRegs[1], 0);

    $display("[TB] SUB/SLT");
    runSingle("or3",   T_OR,  2'd0, 2'd2, 4'd3, 4'd3,  2'd2, 1'b0);
    runSingle("sub5",  T_SUB, 2'd2, 2'd3, 4'd5, 4'd14, 2'd3, 1'b0);
    runSingle("slt5",  T_SLT, 2'd2, 2'd1, 4'd5, 4'd1,  2'd1, 1'b0);
    runSingle("slt2",  T_SLT, 2'd2, 2'd1, 4'd2, 4'd0,  2'd1, 1'b0);

    $display("[TB] backpressure");
    bus.rsp_ready = 1'b0;
    base    = rspCount;
    hsStart = hsCycles.size();
    for (int i = 0; i < 5; i++) begin
      bus.cmd_data  = {T_ADD, 2'd0, 2'd0, 4'd1};
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      checkOutput("bp_ready", bus.cmd_ready, 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("bp_full", bus.cmd_ready, 0);
    repeat (3) @(negedge clk);
    checkOutput("bp_stall", bus.cmd_ready, 0);
    checkOutput("bp_rsp_held", bus.rsp_valid, 1);
    checkOutput("bp_first_data", bus.rsp_data, 1);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 30) begin
      @(negedge clk);
      n++;
      if (bus.cmd_ready) accepted = 1'b1;
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    checkOutput("bp_sixth_accept", accepted, 1);
    n = 0;
    while (rspCount < base + 6 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("bp_rsp_count", rspCount - base, 6);
    if (hsCycles.size() >= hsStart + 5) begin
      for (int i = 1; i < 5; i++)
        checkOutput("bp_spacing", hsCycles[hsStart+i] - hsCycles[hsStart+i-1], 3);
    end else begin
      checkOutput("bp_handshakes", hsCycles.size() - hsStart, 5);
    end
    @(posedge clk);
    #1;
    checkOutput("bp_reg0", calcRegs[0], 6);

    $display("[TB] reset mid-EXEC");
    repeat (3) @(posedge clk);
    #1;
    base = rspCount;
    applyStimulus(T_ADD, 2'd3, 2'd3, 4'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_exec_noop", {calcRdAddr, calcWeAddr, calcImm, calcCtrl}, {2'd0, 2'd0, 4'd0, T_OR});
    checkOutput("rst_exec_ready", bus.cmd_ready, 1);
    #1 rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid) sawValid = 1'b1;
    end
    checkOutput("rst_no_rsp", sawValid, 0);
    checkOutput("rst_rsp_count", rspCount - base, 0);
    checkOutput("rst_ready_after", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("rst_reg3", calcRegs[3], 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
